// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object-RAM DMA sequencer.
// Holds the DMA state encoding and the default sprite-table geometry
// (bytes per frame and source offset in the CPU work-RAM window).
package jtpopeye_pkg;

  localparam int          DMA_AW       = 10;
  localparam int unsigned DMA_LEN      = 640;
  localparam logic [9:0]  DMA_SRC_BASE = 10'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RELEASE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/jtpopeye_obj_dma.sv
// Object-RAM DMA: on each VB rise (with dma_en) grab the CPU bus and copy LEN
//   sprite bytes from CPU RAM (SRC_BASE+n) to object RAM (n), then release it.
// Latency: VB rise -> busrq 2 clk; busak -> first cpu_addr 1 clk; 2 pxl_cen per byte.
// Backpressure: losing busak mid-copy parks in REQ and re-reads the current byte;
//   VB falling early finishes an in-flight write, releases the bus, flags overrun.
// Ports: clk/rst (sync, active high); pxl_cen pacing; VB, dma_en from video timing;
//   busrq/busak arbiter handshake; cpu_addr/cpu_din source read port;
//   obj_addr/obj_dout/obj_we destination write port; busy, overrun status.
module jtpopeye_obj_dma
  import jtpopeye_pkg::*;
#(
  parameter int              AW       = DMA_AW,
  parameter int unsigned     LEN      = DMA_LEN,
  parameter logic [AW-1:0]   SRC_BASE = AW'(DMA_SRC_BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          VB,
  input  logic          dma_en,
  input  logic          busak,
  output logic          busrq,
  output logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy,
  output logic          overrun
);

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  dma_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          vb_q, vb_d;
  logic          start_q, start_d;
  logic          overrun_q, overrun_d;
  logic          busrq_q, busrq_d;
  logic          busy_q, busy_d;
  logic          obj_we_q, obj_we_d;
  logic [AW-1:0] cpu_addr_q, cpu_addr_d;
  logic [AW-1:0] obj_addr_q, obj_addr_d;
  logic [7:0]    obj_dout_q, obj_dout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    vb_d      = VB;
    // dma_en is captured together with the edge so later changes are ignored
    start_d   = VB & ~vb_q & dma_en;

    case (state_q)
      ST_IDLE: begin
        if (start_q) begin
          state_d   = ST_REQ;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (!VB) begin
          state_d   = ST_RELEASE;
          overrun_d = 1'b1;
        end else if (busak) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (!busak) begin
          state_d = ST_REQ;
        end else if (!VB) begin
          state_d   = ST_RELEASE;
          overrun_d = 1'b1;
        end else if (pxl_cen) begin
          data_d  = cpu_din;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Grant loss abandons this byte; cnt is kept so it is fetched again.
        if (!busak) begin
          state_d = ST_REQ;
        end else if (pxl_cen) begin
          if (cnt_q == LAST) begin
            state_d = ST_RELEASE;
          end else if (!VB) begin
            state_d   = ST_RELEASE;
            overrun_d = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_RELEASE: begin
        if (!busak) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register without a combinational output path.
    busrq_d    = (state_d == ST_REQ) || (state_d == ST_READ) || (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    obj_we_d   = (state_d == ST_WRITE);
    cpu_addr_d = SRC_BASE + cnt_d;
    obj_addr_d = cnt_d;
    obj_dout_d = data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      // Track VB through reset so releasing reset during blank is not an edge
      vb_q       <= VB;
      start_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busrq_q    <= 1'b0;
      busy_q     <= 1'b0;
      obj_we_q   <= 1'b0;
      cpu_addr_q <= SRC_BASE;
      obj_addr_q <= '0;
      obj_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      vb_q       <= vb_d;
      start_q    <= start_d;
      overrun_q  <= overrun_d;
      busrq_q    <= busrq_d;
      busy_q     <= busy_d;
      obj_we_q   <= obj_we_d;
      cpu_addr_q <= cpu_addr_d;
      obj_addr_q <= obj_addr_d;
      obj_dout_q <= obj_dout_d;
    end
  end

  assign busrq    = busrq_q;
  assign busy     = busy_q;
  assign obj_we   = obj_we_q;
  assign cpu_addr = cpu_addr_q;
  assign obj_addr = obj_addr_q;
  assign obj_dout = obj_dout_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
// Bench for jtpopeye_obj_dma: two instances (plain base, wrapping base) share
// VB/dma_en/pxl_cen; each has a delayed-grant arbiter and a CPU RAM model.
// Expected object RAM is the source window slice src[(base+i) mod 1024].
`timescale 1ns/1ps
module tb_jtpopeye_obj_dma;

  localparam int         LEN    = 8;
  localparam logic [9:0] BASE_A = 10'h020;
  localparam logic [9:0] BASE_B = 10'h3FC;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, VB, dma_en;
  logic       busak_a, busrq_a, obj_we_a, busy_a, overrun_a;
  logic       busak_b, busrq_b, obj_we_b, busy_b, overrun_b;
  logic [9:0] cpu_addr_a, obj_addr_a, cpu_addr_b, obj_addr_b;
  logic [7:0] cpu_din_a, obj_dout_a, cpu_din_b, obj_dout_b;

  logic [7:0] src_a [1024];
  logic [7:0] src_b [1024];
  logic [7:0] obs_a [1024];
  logic [7:0] obs_b [1024];
  int         stamp_a [1024];
  int         stamp_b [1024];
  int         wr_cnt_a = 0, wr_cnt_b = 0, rq_cnt_a = 0;
  logic [2:0] rq_hist_a = '0, rq_hist_b = '0;
  logic       hold_off_a = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtpopeye_obj_dma #(.AW(10), .LEN(LEN), .SRC_BASE(BASE_A)) dut_a (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .dma_en(dma_en),
    .busak(busak_a), .busrq(busrq_a), .cpu_addr(cpu_addr_a), .cpu_din(cpu_din_a),
    .obj_addr(obj_addr_a), .obj_dout(obj_dout_a), .obj_we(obj_we_a),
    .busy(busy_a), .overrun(overrun_a)
  );

  jtpopeye_obj_dma #(.AW(10), .LEN(LEN), .SRC_BASE(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(VB), .dma_en(dma_en),
    .busak(busak_b), .busrq(busrq_b), .cpu_addr(cpu_addr_b), .cpu_din(cpu_din_b),
    .obj_addr(obj_addr_b), .obj_dout(obj_dout_b), .obj_we(obj_we_b),
    .busy(busy_b), .overrun(overrun_b)
  );

  // CPU RAM: data tracks the address well within one pxl_cen tick
  assign cpu_din_a = src_a[cpu_addr_a];
  assign cpu_din_b = src_b[cpu_addr_b];
  // Arbiter: grant follows request three clocks later; A's grant can be pulled
  assign busak_a = rq_hist_a[2] & ~hold_off_a;
  assign busak_b = rq_hist_b[2];

  initial begin
    pxl_cen = 1'b0;
    forever begin
      @(negedge clk);
      rq_hist_a = {rq_hist_a[1:0], busrq_a};
      rq_hist_b = {rq_hist_b[1:0], busrq_b};
      pxl_cen   = ($urandom_range(0, 3) != 0);
    end
  end

  // Object RAM models: record every committed write with a running stamp
  always @(posedge clk) begin
    if (!rst && obj_we_a && pxl_cen) begin
      obs_a[obj_addr_a]   <= obj_dout_a;
      stamp_a[obj_addr_a] <= wr_cnt_a + 1;
      wr_cnt_a            <= wr_cnt_a + 1;
    end
    if (!rst && obj_we_b && pxl_cen) begin
      obs_b[obj_addr_b]   <= obj_dout_b;
      stamp_b[obj_addr_b] <= wr_cnt_b + 1;
      wr_cnt_b            <= wr_cnt_b + 1;
    end
    if (busrq_a) rq_cnt_a <= rq_cnt_a + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic fill_src(input bit fixed);
    logic [7:0] r;
    logic [9:0] k;
    r = 8'($urandom);
    for (int i = 0; i < 1024; i++) begin
      k = 10'(i);
      src_a[i] = 8'($urandom);
      src_b[i] = k[7:0] ^ r;
    end
    if (fixed) for (int i = 0; i < LEN; i++) src_a[BASE_A + 10'(i)] = 8'h10 + 8'(i);
  endtask

  task automatic start_frame();
    VB = 1'b0;
    repeat (3) @(negedge clk);
    VB = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input bit toggle_en);
    int n = 0;
    while ((busy_a || busy_b) && n < 800) begin
      @(negedge clk);
      if (toggle_en && $urandom_range(0, 4) == 0) dma_en = ~dma_en;
      n++;
    end
    checks++;
    if (busy_a || busy_b) begin
      failures++;
      $display("FAIL %s_timeout busy_a=%0b busy_b=%0b expected 0", tag, busy_a, busy_b);
    end
  endtask

  // Bytes [0, n_ok) must hold the source slice and be written this frame;
  // bytes [n_ok, LEN) must not have been written this frame.
  task automatic check_frame(input string tag, input bit is_b, input int base, input int n_ok);
    for (int i = 0; i < LEN; i++) begin
      logic [9:0] sa;
      logic [7:0] got, exp;
      bit         wr;
      sa  = (is_b ? BASE_B : BASE_A) + 10'(i);
      got = is_b ? obs_b[i] : obs_a[i];
      exp = is_b ? src_b[sa] : src_a[sa];
      wr  = is_b ? (stamp_b[i] > base) : (stamp_a[i] > base);
      checks++;
      if (i < n_ok) begin
        if (!wr || got !== exp) begin
          failures++;
          $display("FAIL %s byte%0d got=%h written=%0b expected=%h", tag, i, got, wr, exp);
        end
      end else if (wr) begin
        failures++;
        $display("FAIL %s byte%0d unexpected write got=%h expected none", tag, i, got);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; VB = 1'b0; dma_en = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (busrq_a !== 1'b0)    begin failures++; $display("FAIL reset_busrq got=%b expected 0", busrq_a); end
    if (obj_we_a !== 1'b0)   begin failures++; $display("FAIL reset_obj_we got=%b expected 0", obj_we_a); end
    if (busy_a !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b expected 0", busy_a); end
    if (overrun_a !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%b expected 0", overrun_a); end
    if (cpu_addr_a !== BASE_A) begin failures++; $display("FAIL reset_cpu_addr got=%h expected %h", cpu_addr_a, BASE_A); end
    if (cpu_addr_b !== BASE_B) begin failures++; $display("FAIL reset_cpu_addr_b got=%h expected %h", cpu_addr_b, BASE_B); end
    if (obj_addr_a !== 10'd0) begin failures++; $display("FAIL reset_obj_addr got=%h expected 0", obj_addr_a); end
    if (obj_dout_a !== 8'd0)  begin failures++; $display("FAIL reset_obj_dout got=%h expected 0", obj_dout_a); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int base = wr_cnt_a;
    fill_src(1'b1);
    dma_en = 1'b1;
    VB = 1'b0;
    repeat (3) @(negedge clk);
    VB = 1'b1;
    @(negedge clk);
    checks++;
    if (busrq_a !== 1'b0) begin failures++; $display("FAIL basic_busrq_early got=%b expected 0 one clk after VB rise", busrq_a); end
    @(negedge clk);
    checks++;
    if (busrq_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++; $display("FAIL basic_busrq_latency busrq=%b busy=%b expected 1/1 two clk after VB rise", busrq_a, busy_a);
    end
    wait_done("basic", 1'b0);
    checks += 2;
    if (wr_cnt_a - base != LEN) begin failures++; $display("FAIL basic_write_count got=%0d expected %0d", wr_cnt_a - base, LEN); end
    if (overrun_a !== 1'b0 || busrq_a !== 1'b0) begin
      failures++; $display("FAIL basic_end overrun=%b busrq=%b expected 0/0", overrun_a, busrq_a);
    end
    check_frame("basic", 1'b0, base, LEN);
    VB = 1'b0;
  endtask

  task automatic test_dma_disabled();
    int base = wr_cnt_a;
    int rq0  = rq_cnt_a;
    dma_en = 1'b0;
    start_frame();
    repeat (40) @(negedge clk);
    checks += 2;
    if (rq_cnt_a != rq0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL disabled_busrq request_cycles=%0d busy=%b expected 0/0", rq_cnt_a - rq0, busy_a);
    end
    if (wr_cnt_a != base) begin failures++; $display("FAIL disabled_writes got=%0d expected 0", wr_cnt_a - base); end
    VB = 1'b0;
  endtask

  task automatic test_busak_drop();
    int  base = wr_cnt_a;
    int  n = 0;
    bit  rq_ok = 1'b1;
    fill_src(1'b1);
    dma_en = 1'b1;
    start_frame();
    while (!(obj_we_a && obj_addr_a == 10'd3) && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (!(obj_we_a && obj_addr_a == 10'd3)) begin failures++; $display("FAIL busak_reach_byte3 obj_we=%b obj_addr=%h expected 1/003", obj_we_a, obj_addr_a); end
    hold_off_a = 1'b1;
    repeat (5) begin @(negedge clk); if (busrq_a !== 1'b1) rq_ok = 1'b0; end
    hold_off_a = 1'b0;
    checks++;
    if (!rq_ok) begin failures++; $display("FAIL busak_drop_busrq got=0 during grant loss expected 1"); end
    wait_done("busak_drop", 1'b0);
    checks += 2;
    if (wr_cnt_a - base < LEN || wr_cnt_a - base > LEN + 1) begin
      failures++; $display("FAIL busak_drop_count got=%0d expected %0d or %0d", wr_cnt_a - base, LEN, LEN + 1);
    end
    if (overrun_a !== 1'b0) begin failures++; $display("FAIL busak_drop_overrun got=%b expected 0", overrun_a); end
    check_frame("busak_drop", 1'b0, base, LEN);
    VB = 1'b0;
  endtask

  task automatic test_vb_fall();
    int base = wr_cnt_a;
    int n = 0;
    fill_src(1'b0);
    dma_en = 1'b1;
    start_frame();
    while (stamp_a[4] <= base && n < 400) begin @(negedge clk); n++; end
    VB = 1'b0;
    wait_done("vb_fall", 1'b0);
    checks++;
    if (overrun_a !== 1'b1) begin failures++; $display("FAIL vb_fall_overrun got=%b expected 1", overrun_a); end
    check_frame("vb_fall", 1'b0, base, 5);
    base = wr_cnt_a;
    fill_src(1'b0);
    start_frame();
    wait_done("vb_next", 1'b0);
    checks++;
    if (overrun_a !== 1'b0) begin failures++; $display("FAIL vb_next_overrun got=%b expected 0", overrun_a); end
    check_frame("vb_next", 1'b0, base, LEN);
    VB = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base = wr_cnt_a;
    int n = 0;
    fill_src(1'b0);
    dma_en = 1'b1;
    start_frame();
    while (stamp_a[2] <= base && n < 400) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busrq_a !== 1'b0 || obj_we_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL reset_mid busrq=%b obj_we=%b busy=%b expected 0/0/0", busrq_a, obj_we_a, busy_a);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    base = wr_cnt_a;
    fill_src(1'b0);
    start_frame();
    wait_done("reset_restart", 1'b0);
    checks += 2;
    if (stamp_a[0] != base + 1) begin failures++; $display("FAIL reset_restart_first stamp=%0d expected %0d", stamp_a[0], base + 1); end
    if (wr_cnt_a - base != LEN) begin failures++; $display("FAIL reset_restart_count got=%0d expected %0d", wr_cnt_a - base, LEN); end
    check_frame("reset_restart", 1'b0, base, LEN);
    VB = 1'b0;
  endtask

  task automatic test_wrap();
    int base = wr_cnt_b;
    fill_src(1'b0);
    dma_en = 1'b1;
    start_frame();
    wait_done("wrap", 1'b0);
    checks += 2;
    if (wr_cnt_b - base != LEN) begin failures++; $display("FAIL wrap_count got=%0d expected %0d", wr_cnt_b - base, LEN); end
    if (overrun_b !== 1'b0) begin failures++; $display("FAIL wrap_overrun got=%b expected 0", overrun_b); end
    check_frame("wrap", 1'b1, base, LEN);
    VB = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      int base_a = wr_cnt_a;
      int base_b = wr_cnt_b;
      bit en = ($urandom_range(0, 3) != 0);
      fill_src(1'b0);
      dma_en = en;
      start_frame();
      wait_done("random", 1'b1);
      repeat (10) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0) begin failures++; $display("FAIL random%0d_idle busy=%b expected 0", f, busy_a); end
      check_frame("random_a", 1'b0, base_a, en ? LEN : 0);
      check_frame("random_b", 1'b1, base_b, en ? LEN : 0);
      VB = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_dma_disabled();
    test_busak_drop();
    test_vb_fall();
    test_reset_mid();
    test_wrap();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
